// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side master for a single-port view of a dual-port RAM. A transfer is
//   requested with a base address and a word count. The block issues one read
//   per clock, absorbs the RAM's one-cycle registered read latency through a
//   two-entry FIFO, and presents the words as a valid/ready stream. With an
//   always-ready consumer it sustains one word per clock.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   start, base, count   transfer request (sampled only while idle)
//   busy, done, err      status: transfer active, completion pulse, reject pulse
//   ram_we, ram_din      write side of the RAM port, held inactive
//   ram_oe, ram_address  read strobe and read address to the RAM
//   ram_dout             RAM read data, valid the cycle after ram_oe
//   ram_length           RAM size in words, bounds the accepted count
//   m_valid, m_ready     output stream handshake
//   m_data, m_last       output word and end-of-transfer marker

module bram_stream_reader #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DEPTH-1:0]   base,
    input  logic [DEPTH:0]     count,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               ram_we,
    output logic               ram_oe,
    output logic [DEPTH-1:0]   ram_address,
    output logic [WIDTH-1:0]   ram_din,
    input  logic [WIDTH-1:0]   ram_dout,
    input  logic [31:0]        ram_length,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_last
);

    // state   | meaning
    // S_IDLE  | waiting for start; count checked against ram_length here
    // S_RUN   | reads still to be issued
    // S_DRAIN | all reads issued, waiting for the last word to be accepted
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [DEPTH:0]   CNT_ONE  = (DEPTH+1)'(1);
    localparam logic [DEPTH-1:0] ADDR_ONE = DEPTH'(1);

    state_t             state_q, state_d;
    logic [DEPTH:0]     issue_left_q, issue_left_d;
    logic [DEPTH:0]     out_left_q, out_left_d;
    logic [DEPTH-1:0]   addr_q, addr_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               inflight_q;

    logic [WIDTH-1:0]   fifo_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         occ_q;

    logic               pop;
    logic               issue;
    logic               count_ok;
    logic [2:0]         pending;

    assign ram_we      = 1'b0;
    assign ram_din     = '0;
    assign ram_address = addr_q;
    assign ram_oe      = issue;

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = fifo_q[rd_ptr_q];
    assign m_last  = m_valid && (out_left_q == CNT_ONE);
    assign pop     = m_valid && m_ready;

    assign count_ok = (32'(count) <= ram_length);

    // Words already buffered or on their way back from the RAM, less the one
    // leaving this cycle. A new read is only issued when it is guaranteed a
    // FIFO slot by the time its data returns, so the FIFO write never stalls.
    // The read strobe is decided in the same cycle it is driven; deferring it
    // a register stage would cost a third FIFO entry to keep full rate.
    assign pending = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

    always_comb begin
        state_d      = state_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        addr_d       = addr_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        issue        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else if (!count_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d      = S_RUN;
                        issue_left_d = count;
                        out_left_d   = count;
                        addr_d       = base;
                    end
                end
            end
            S_RUN: begin
                if ((issue_left_q != '0) && (pending < 3'd2)) begin
                    issue        = 1'b1;
                    addr_d       = addr_q + ADDR_ONE;
                    issue_left_d = issue_left_q - CNT_ONE;
                    if (issue_left_q == CNT_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            out_left_d = out_left_q - CNT_ONE;
            if (m_last) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            issue_left_q <= '0;
            out_left_q   <= '0;
            addr_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            addr_q       <= addr_d;
            done_q       <= done_d;
            err_q        <= err_d;
            inflight_q   <= issue;
        end
    end

    // Two-entry FIFO; the write is unconditional on the cycle after a read
    // because the issue rule has already reserved the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= ram_dout;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + 2'(inflight_q) - 2'(pop);
        end
    end

endmodule
